multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Sequenced control unit for the 9-bit-instruction processor. Replaces single-cycle control decoding with a state machine that accepts one instruction per valid/ready handshake and issues one-cycle commit pulses. Loads wait a parametrised data-memory latency before write-back. Sits between the instruction fetch stage and the datapath (reg file, ALU, data memory, PC logic).

## Interface
Parameters:
- MCODEBITS, 9, instruction width; opcode is instr[MCODEBITS-1 -: 3]
- OPWIDTH, 3, ALUOp width
- MEM_LAT, 2, data-memory read latency in cycles; legal range is 1 or more

Ports:
- clk  in  1  sole clock; rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch presents an instruction
- instr  in  MCODEBITS  machine code; captured on handshake
- instr_ready  out  1  controller can accept; high only in IDLE
- zero  in  1  ALU zero flag; sampled in EXEC
- Branch, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  datapath controls
- how_high  out  2  branch target select, equal to instr[4:3]
- ALUOp  out  OPWIDTH  ALU operation
- sc_en, sc_clr  out  1 each  shift-carry enable and clear; mutually exclusive
- pc_en  out  1  one-cycle PC advance/branch commit
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: accepts on instr_valid && instr_ready and latches instr into ir. Goes to EXEC.
  - EXEC:
    - Goes to MEM if the opcode is load.
    - Otherwise goes to IDLE.
  - MEM: counts MEM_LAT cycles, then goes to WB.
  - WB: goes to IDLE.
- All outputs are a function of the registered state and ir. In IDLE and MEM every control output is 0, except MemtoReg, which is 1 in MEM for a load.
- EXEC actions by opcode (ir[8:6]):
  - 000 add, 011 nand, 100 sub: ALUOp equals the opcode; RegWrite=1; sc_clr=1; pc_en=1.
  - 001 lshift, 010 rshift: ALUOp equals the opcode; RegWrite=1; sc_en=1; pc_en=1.
  - 101 load: ALUOp=000 (address pass). No write in EXEC.
  - 110 store: MemWrite=1; sc_clr=1; pc_en=1.
  - 111 with ir[5]=1 (addi): ALUOp=000; ALUSrc=1; RegWrite=1; sc_clr=1; pc_en=1.
  - 111 with ir[5]=0 (branch): Branch = ~zero; how_high = ir[4:3]; sc_clr=1; pc_en=1.
- WB (load only): MemtoReg=1, RegWrite=1, sc_clr=1, pc_en=1.
- Invariants:
  - RegWrite, MemWrite and pc_en each pulse exactly once per instruction.
  - sc_en and sc_clr are never high together.
- Wait counter:
  - Width is $clog2(MEM_LAT+1).
  - Loads 0 on entry to MEM and increments each cycle.
  - Leaves MEM when the count equals MEM_LAT-1.
  - Saturates; it never wraps.

## Timing
- Reset (async assert, synchronous release via flops):
  - state=IDLE, ir=0, counter=0.
  - All control outputs 0, instr_ready=1, busy=0.
- Handshake accepted at edge T: EXEC occupies cycle T+1.
- ALU/addi/store/branch: commit pulses in cycle T+1; IDLE again at T+2. Throughput is 1 instruction per 2 cycles.
- Load:
  - MEM occupies cycles T+2 .. T+1+MEM_LAT.
  - WB occurs at T+2+MEM_LAT.
  - IDLE again at T+3+MEM_LAT.
- instr_valid while busy: ignored, no latch. Fetch must hold instr stable until ready.
- zero is sampled only in the EXEC cycle of a branch. Changes to zero in other cycles have no effect.
- reset_n asserted mid-instruction:
  - Immediate return to IDLE.
  - Any in-flight pulse is dropped combinationally the same cycle.
  - No WB for an aborted load.

## Configuration
- MULTICYCLE_CTRL_PERF_EN:
  - When defined, adds outputs perf_instr (32-bit count of pc_en pulses) and perf_stall (32-bit count of MEM cycles).
  - Both counters are reset to 0 by reset_n and wrap modulo 2^32.
  - When undefined, these ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Package ctrl_pkg holds:
  - opcode constants OP_ADD..OP_BRI (3'b000..3'b111);
  - ALUOp constants;
  - state enum {IDLE, EXEC, MEM, WB}.
- Sub-module ctrl_decode is the pure combinational map from (state, ir, zero) to control outputs. The top holds the state register, ir and the wait counter.

## Test plan
- Reset mid-MEM of a load, then release. Required: outputs all 0 and instr_ready=1 during reset, and no RegWrite afterwards.
- add (9'b000_xxxxxx), instr_valid held for 1 cycle. Required:
  - RegWrite=1, ALUOp=000, sc_clr=1, pc_en=1 in exactly cycle T+1;
  - instr_ready=0 in T+1.
- Load with MEM_LAT=2. Required:
  - busy for 4 cycles;
  - MemtoReg=1 with RegWrite=1 only at T+4;
  - pc_en once.
- Branch 9'b111_0_10_xxx with zero=0 in EXEC. Required: Branch=1, how_high=2'b10. Repeat with zero=1: Branch=0, pc_en=1.
- Back-to-back: lshift then store with instr_valid held high. Required:
  - accepted at T and T+2;
  - sc_en=1 at T+1, MemWrite=1 at T+3;
  - sc_en and sc_clr never high together.
- With MULTICYCLE_CTRL_PERF_EN defined, run 3 ALU ops and 1 load (MEM_LAT=2). Required: perf_instr=4, perf_stall=2.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
//   - opcode constants (instr[MCODEBITS-1 -: 3])
//   - ALUOp encodings
//   - controller state enum
//   - is_load helper
package ctrl_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_LSH   = 3'b001;
    localparam logic [2:0] OP_RSH   = 3'b010;
    localparam logic [2:0] OP_NAND  = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_BRI   = 3'b111;

    // ALU encodings mirror the opcode for register-register ops; add doubles as
    // the address/immediate pass-through.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_LSH  = 3'b001;
    localparam logic [2:0] ALU_RSH  = 3'b010;
    localparam logic [2:0] ALU_NAND = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MEM  = 2'b10,
        WB   = 2'b11
    } state_t;

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational map from (state, ir fields, zero) to the
// datapath control outputs.
// Ports:
//   i_state    current controller state
//   i_opcode   ir opcode field
//   i_imm      ir[5] (addi vs branch select for opcode 111)
//   i_how      ir[4:3] branch target select
//   i_zero     ALU zero flag (only consulted for a branch in EXEC)
//   o_*        control outputs, all 0 outside the states that drive them
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPWIDTH = 3
) (
    input  state_t             i_state,
    input  logic [2:0]         i_opcode,
    input  logic               i_imm,
    input  logic [1:0]         i_how,
    input  logic               i_zero,
    output logic               o_branch,
    output logic               o_memtoreg,
    output logic               o_memwrite,
    output logic               o_alusrc,
    output logic               o_regwrite,
    output logic [1:0]         o_how_high,
    output logic [OPWIDTH-1:0] o_aluop,
    output logic               o_sc_en,
    output logic               o_sc_clr,
    output logic               o_pc_en
);

    // Control decode: everything defaults low, each state raises only its own pulses.
    always_comb begin
        o_branch   = 1'b0;
        o_memtoreg = 1'b0;
        o_memwrite = 1'b0;
        o_alusrc   = 1'b0;
        o_regwrite = 1'b0;
        o_how_high = 2'b00;
        o_aluop    = '0;
        o_sc_en    = 1'b0;
        o_sc_clr   = 1'b0;
        o_pc_en    = 1'b0;
        case (i_state)
            EXEC: begin
                case (i_opcode)
                    OP_ADD, OP_NAND, OP_SUB: begin
                        if (i_opcode == OP_ADD) begin
                            o_aluop = OPWIDTH'(ALU_ADD);
                        end else if (i_opcode == OP_NAND) begin
                            o_aluop = OPWIDTH'(ALU_NAND);
                        end else begin
                            o_aluop = OPWIDTH'(ALU_SUB);
                        end
                        o_regwrite = 1'b1;
                        o_sc_clr   = 1'b1;
                        o_pc_en    = 1'b1;
                    end
                    OP_LSH, OP_RSH: begin
                        if (i_opcode == OP_LSH) begin
                            o_aluop = OPWIDTH'(ALU_LSH);
                        end else begin
                            o_aluop = OPWIDTH'(ALU_RSH);
                        end
                        o_regwrite = 1'b1;
                        o_sc_en    = 1'b1;
                        o_pc_en    = 1'b1;
                    end
                    OP_LOAD: begin
                        // Address computation only; commit happens in WB.
                        o_aluop = OPWIDTH'(ALU_ADD);
                    end
                    OP_STORE: begin
                        o_memwrite = 1'b1;
                        o_sc_clr   = 1'b1;
                        o_pc_en    = 1'b1;
                    end
                    OP_BRI: begin
                        if (i_imm) begin
                            o_aluop    = OPWIDTH'(ALU_ADD);
                            o_alusrc   = 1'b1;
                            o_regwrite = 1'b1;
                        end else begin
                            // Branch taken when the compared values differ.
                            o_branch   = ~i_zero;
                            o_how_high = i_how;
                        end
                        o_sc_clr = 1'b1;
                        o_pc_en  = 1'b1;
                    end
                    default: begin
                        o_aluop = '0;
                    end
                endcase
            end
            MEM: begin
                o_memtoreg = is_load(i_opcode);
            end
            WB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
                o_sc_clr   = 1'b1;
                o_pc_en    = 1'b1;
            end
            default: begin
                o_pc_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequenced control unit for the 9-bit-instruction processor.
// Accepts one instruction per valid/ready handshake (only in IDLE), executes
// it in EXEC, and for loads waits MEM_LAT cycles in MEM before a WB commit.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds perf_instr (pc_en
// pulse count) and perf_stall (MEM cycle count), both 32-bit wrapping.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   instr_valid/instr      fetch handshake and instruction
//   instr_ready, busy      IDLE / not-IDLE status
//   zero                   ALU zero flag, used by branches in EXEC
//   Branch..pc_en          datapath control outputs (from ctrl_decode)
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MCODEBITS = 9,
    parameter int OPWIDTH   = 3,
    parameter int MEM_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 instr_valid,
    input  logic [MCODEBITS-1:0] instr,
    output logic                 instr_ready,
    input  logic                 zero,
    output logic                 Branch,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic [1:0]           how_high,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 sc_en,
    output logic                 sc_clr,
    output logic                 pc_en,
    output logic                 busy
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_instr,
    output logic [31:0]          perf_stall
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t                r_state;
    logic [MCODEBITS-1:0]  r_ir;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            w_opcode;
    logic                  w_unused_ir;

    assign w_opcode    = r_ir[MCODEBITS-1 -: 3];
    assign w_unused_ir = ^r_ir;
    assign instr_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);

    // State register, instruction register and memory wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= EXEC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EXEC: begin
                    if (is_load(w_opcode)) begin
                        r_cnt   <= '0;
                        r_state <= MEM;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                MEM: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= WB;
                    end else begin
                        r_state <= MEM;
                    end
                    // Saturating count so a stray extra cycle can never wrap back to 0.
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ctrl_decode #(
        .OPWIDTH (OPWIDTH)
    ) u_decode (
        .i_state    (r_state),
        .i_opcode   (w_opcode),
        .i_imm      (r_ir[5]),
        .i_how      (r_ir[4:3]),
        .i_zero     (zero),
        .o_branch   (Branch),
        .o_memtoreg (MemtoReg),
        .o_memwrite (MemWrite),
        .o_alusrc   (ALUSrc),
        .o_regwrite (RegWrite),
        .o_how_high (how_high),
        .o_aluop    (ALUOp),
        .o_sc_en    (sc_en),
        .o_sc_clr   (sc_clr),
        .o_pc_en    (pc_en)
    );

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_stall;

    // Performance counters: committed instructions and memory wait cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_instr <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (pc_en) begin
                r_perf_instr <= r_perf_instr + 32'd1;
            end else begin
                r_perf_instr <= r_perf_instr;
            end
            if (r_state == MEM) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end else begin
                r_perf_stall <= r_perf_stall;
            end
        end
    end

    assign perf_instr = r_perf_instr;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (MEM_LAT = 2).
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       zero;
    logic       Branch, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0] how_high;
    logic [2:0] ALUOp;
    logic       sc_en, sc_clr, pc_en, busy;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_instr, perf_stall;
`endif

    int checks;
    int errors;

    // {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, sc_en, sc_clr, pc_en}
    logic [7:0] ctl;
    assign ctl = {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, sc_en, sc_clr, pc_en};

    multicycle_ctrl #(.MCODEBITS(9), .OPWIDTH(3), .MEM_LAT(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .zero        (zero),
        .Branch      (Branch),
        .MemtoReg    (MemtoReg),
        .MemWrite    (MemWrite),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite),
        .how_high    (how_high),
        .ALUOp       (ALUOp),
        .sc_en       (sc_en),
        .sc_clr      (sc_clr),
        .pc_en       (pc_en),
        .busy        (busy)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .perf_instr  (perf_instr),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ctl, how_high, ALUOp, instr_ready, busy} !== {8'h00, 2'b00, 3'b000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b hh=%b alu=%b rdy=%b busy=%b want ctl=0 hh=0 alu=0 rdy=1 busy=0",
                     ctl, how_high, ALUOp, instr_ready, busy);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_add;
        instr = 9'b000_101_011;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({ctl, ALUOp, instr_ready} !== {8'b0000_1011, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL add_exec got ctl=%b alu=%b rdy=%b want ctl=00001011 alu=000 rdy=0", ctl, ALUOp, instr_ready);
        end
        tick();
        checks++;
        if ({ctl, instr_ready, busy} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_after got ctl=%b rdy=%b busy=%b want ctl=0 rdy=1 busy=0", ctl, instr_ready, busy);
        end
    endtask

    task automatic test_load;
        int busy_cnt, pc_cnt, rw_cnt, wb_cyc;
        busy_cnt = 0; pc_cnt = 0; rw_cnt = 0; wb_cyc = 0;
        instr = 9'b101_001_010;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (busy) busy_cnt++;
            if (pc_en) pc_cnt++;
            if (RegWrite) rw_cnt++;
            if (MemtoReg && RegWrite) wb_cyc = i;
            if (i == 1) begin
                checks++;
                if ({ctl, ALUOp} !== {8'h00, 3'b000}) begin
                    errors++;
                    $display("FAIL load_exec got ctl=%b alu=%b want ctl=0 alu=000", ctl, ALUOp);
                end
            end
            if (i == 2) begin
                checks++;
                if (ctl !== 8'b0100_0000) begin
                    errors++;
                    $display("FAIL load_mem got ctl=%b want 01000000", ctl);
                end
            end
            if (i == 4) begin
                checks++;
                if (ctl !== 8'b0100_1011) begin
                    errors++;
                    $display("FAIL load_wb got ctl=%b want 01001011", ctl);
                end
            end
            tick();
        end
        checks++;
        if ({busy_cnt, pc_cnt, rw_cnt, wb_cyc} !== {32'd4, 32'd1, 32'd1, 32'd4}) begin
            errors++;
            $display("FAIL load_counts got busy=%0d pc=%0d rw=%0d wb_at=%0d want busy=4 pc=1 rw=1 wb_at=4",
                     busy_cnt, pc_cnt, rw_cnt, wb_cyc);
        end
    endtask

    task automatic test_branch;
        // zero=0 in EXEC -> taken
        instr = 9'b111_0_10_101;
        zero = 1'b0;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({ctl, how_high} !== {8'b1000_0011, 2'b10}) begin
            errors++;
            $display("FAIL branch_taken got ctl=%b hh=%b want ctl=10000011 hh=10", ctl, how_high);
        end
        tick();
        // zero changing outside EXEC must not raise Branch
        zero = 1'b1;
        #1;
        checks++;
        if (Branch !== 1'b0) begin
            errors++;
            $display("FAIL branch_idle_zero got %b want 0", Branch);
        end
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({ctl, how_high} !== {8'b0000_0011, 2'b10}) begin
            errors++;
            $display("FAIL branch_not_taken got ctl=%b hh=%b want ctl=00000011 hh=10", ctl, how_high);
        end
        tick();
        // addi shares the opcode but uses ALUSrc
        instr = 9'b111_1_01_011;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({ctl, how_high, ALUOp} !== {8'b0001_1011, 2'b00, 3'b000}) begin
            errors++;
            $display("FAIL addi_exec got ctl=%b hh=%b alu=%b want ctl=00011011 hh=00 alu=000", ctl, how_high, ALUOp);
        end
        tick();
        zero = 1'b0;
    endtask

    task automatic test_back_to_back;
        int both;
        both = 0;
        instr = 9'b001_010_011;
        instr_valid = 1'b1;
        tick();
        if (sc_en && sc_clr) both++;
        checks++;
        if ({ctl, ALUOp, instr_ready} !== {8'b0000_1101, 3'b001, 1'b0}) begin
            errors++;
            $display("FAIL b2b_lshift got ctl=%b alu=%b rdy=%b want ctl=00001101 alu=001 rdy=0", ctl, ALUOp, instr_ready);
        end
        instr = 9'b110_011_100;
        tick();
        if (sc_en && sc_clr) both++;
        checks++;
        if ({ctl, instr_ready} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL b2b_gap got ctl=%b rdy=%b want ctl=0 rdy=1", ctl, instr_ready);
        end
        tick();
        if (sc_en && sc_clr) both++;
        instr_valid = 1'b0;
        checks++;
        if (ctl !== 8'b0010_0011) begin
            errors++;
            $display("FAIL b2b_store got ctl=%b want 00100011", ctl);
        end
        tick();
        if (sc_en && sc_clr) both++;
        checks++;
        if ({both, busy} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_sc_excl got overlaps=%0d busy=%b want overlaps=0 busy=0", both, busy);
        end
    endtask

    task automatic test_reset_mid_load;
        int rw_cnt;
        rw_cnt = 0;
        instr = 9'b101_000_001;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++;
        if (MemtoReg !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_mem got MemtoReg=%b want 1", MemtoReg);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ctl, instr_ready, busy} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrst_during got ctl=%b rdy=%b busy=%b want ctl=0 rdy=1 busy=0", ctl, instr_ready, busy);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RegWrite || busy) rw_cnt++;
        end
        checks++;
        if (rw_cnt !== 0) begin
            errors++;
            $display("FAIL midrst_no_wb got active_cycles=%0d want 0", rw_cnt);
        end
    endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
    task automatic test_perf;
        logic [8:0] prog [4];
        prog[0] = 9'b000_001_010;
        prog[1] = 9'b011_001_010;
        prog[2] = 9'b100_001_010;
        prog[3] = 9'b101_001_010;
        do_reset();
        checks++;
        if ({perf_instr, perf_stall} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL perf_reset got instr=%0d stall=%0d want 0 0", perf_instr, perf_stall);
        end
        for (int k = 0; k < 4; k++) begin
            instr = prog[k];
            instr_valid = 1'b1;
            tick();
            instr_valid = 1'b0;
            for (int w = 0; w < 6 && busy; w++) tick();
        end
        tick();
        checks++;
        if ({perf_instr, perf_stall} !== {32'd4, 32'd2}) begin
            errors++;
            $display("FAIL perf_counts got instr=%0d stall=%0d want 4 2", perf_instr, perf_stall);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        instr_valid = 1'b0;
        instr = 9'd0;
        zero = 1'b0;
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_back_to_back();
        test_reset_mid_load();
`ifdef MULTICYCLE_CTRL_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
